// File: rtl/phys_reg_free_list_if.sv
// Rename/commit port bundle of the physical register free list.
interface phys_reg_free_list_if;
  localparam int unsigned PREG_W = 6;

  logic              alloc_req;
  logic              alloc_valid;
  logic [PREG_W-1:0] alloc_preg;
  logic              free_valid;
  logic [PREG_W-1:0] free_preg;
  logic              ckpt_save;
  logic              ckpt_restore;
  logic [PREG_W-1:0] free_count;
  logic              error;

  // Rename/commit side.
  modport master (
    output alloc_req, free_valid, free_preg, ckpt_save, ckpt_restore,
    input  alloc_valid, alloc_preg, free_count, error
  );

  // Free list side.
  modport slave (
    input  alloc_req, free_valid, free_preg, ckpt_save, ckpt_restore,
    output alloc_valid, alloc_preg, free_count, error
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical registers with a single head checkpoint
// for one-cycle branch mispredict recovery.
module phys_reg_free_list #(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned FIRST_FREE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  phys_reg_free_list_if.slave  bus
);
  localparam int unsigned PREG_W = 6;
  localparam int unsigned PTR_W  = 6;
  localparam int unsigned IDX_W  = 5;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

  logic [PREG_W-1:0] entries [DEPTH];

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  ckpt_head;
  logic [PTR_W-1:0]  free_count;
  logic              error;

  logic [PTR_W-1:0]  head_nxt;
  logic [PTR_W-1:0]  tail_nxt;
  logic [PTR_W-1:0]  ckpt_nxt;
  logic [PTR_W-1:0]  count;
  logic [PTR_W-1:0]  count_nxt;
  logic [PTR_W-1:0]  restore_span;
  logic              error_nxt;
  logic              alloc_fire;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;

  // Occupancy from the wrap-bit pointers.
  assign count = tail - head;

  // Grant is combinational; a restore cycle never grants.
  assign bus.alloc_valid = (count != '0) && !bus.ckpt_restore;
  assign bus.alloc_preg  = entries[head[IDX_W-1:0]];
  assign bus.free_count  = free_count;
  assign bus.error       = error;

  // Next-state pointers, checkpoint and protocol error.
  always_comb begin
    head_nxt     = head;
    tail_nxt     = tail;
    ckpt_nxt     = ckpt_head;
    error_nxt    = error;
    wr_en        = 1'b0;
    wr_idx       = tail[IDX_W-1:0];
    alloc_fire   = bus.alloc_req && bus.alloc_valid;
    restore_span = '0;

    if (bus.ckpt_restore) begin
      head_nxt = ckpt_head;
    end else if (alloc_fire) begin
      head_nxt = head + ONE_P;
    end

    // Full is judged on the pre-edge count; returning the zero reg is illegal.
    if (bus.free_valid) begin
      if ((count == DEPTH_P) || (bus.free_preg == '0)) begin
        error_nxt = 1'b1;
      end else begin
        wr_en    = 1'b1;
        tail_nxt = tail + ONE_P;
      end
    end

    // Snapshot the post-alloc head; a concurrent restore takes precedence.
    if (bus.ckpt_save && !bus.ckpt_restore) begin
      ckpt_nxt = head_nxt;
    end

    // More regs returned than were speculatively allocated since the snapshot.
    restore_span = tail_nxt - ckpt_head;
    if (bus.ckpt_restore && (restore_span > DEPTH_P)) begin
      error_nxt = 1'b1;
    end

    count_nxt = tail_nxt - head_nxt;
  end

  // Pointer, checkpoint, count and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      tail       <= DEPTH_P;
      ckpt_head  <= '0;
      free_count <= DEPTH_P;
      error      <= 1'b0;
    end else begin
      head       <= head_nxt;
      tail       <= tail_nxt;
      ckpt_head  <= ckpt_nxt;
      free_count <= count_nxt;
      error      <= error_nxt;
    end
  end

  // Free list storage; reset loads the identity of the non-architectural regs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[IDX_W'(i)] <= PREG_W'(FIRST_FREE + i);
      end
    end else if (wr_en) begin
      entries[wr_idx] <= bus.free_preg;
    end
  end
endmodule
